pair_stream_checker: RTL and testbench
======================================

PAIR_STREAM_CHECKER -- requirements
Module: pair_stream_checker

Interface
REQ-001 SHALL have parameter N_PAIRS, default 512, the number of 32-bit read words expected per frame.
REQ-002 SHALL have parameter TIMEOUT, default 64, the maximum idle cycles in RUN between accepted pairs.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1 bit, a one-cycle pulse that arms a frame check.
REQ-006 SHALL have port in_valid, input, 1 bit, marking data_in1/data_in2 as a valid pair this cycle.
REQ-007 SHALL have ports data_in1 and data_in2, input, 16 bits each, the low and high halves of one read word from the upstream dual-port buffer.
REQ-008 SHALL have port busy, output, 1 bit, high in RUN.
REQ-009 SHALL have port done, output, 1 bit, a one-cycle pulse at frame end.
REQ-010 SHALL have port sum, output, 32 bits, the running sum of both lanes over accepted pairs.
REQ-011 SHALL have port err_cnt, output, 10 bits, the count of mismatching pairs, saturating at 1023.
REQ-012 SHALL have port first_err_idx, output, 9 bits, the pair index of the first mismatch, valid when err_cnt>0.
REQ-013 SHALL have port timeout, output, 1 bit, a sticky flag set when the frame ended by TIMEOUT.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, DONE: IDLE->RUN on start; RUN->DONE when pair count reaches N_PAIRS or idle counter reaches TIMEOUT; DONE->IDLE unconditionally after one cycle.
REQ-015 SHALL, on the IDLE->RUN transition, clear sum, err_cnt, first_err_idx, timeout, pair counter and idle counter in the same edge.
REQ-016 SHALL accept a pair only when state is RUN and in_valid=1, and ignore in_valid in IDLE and DONE.
REQ-017 SHALL treat pair k (0-based) as correct iff data_in1==2k+1 and data_in2==2k+2, computed modulo 2^16.
REQ-018 SHALL add zero-extended data_in1+data_in2 into sum on each accepted pair, with 32-bit wrap-around.
REQ-019 SHALL increment err_cnt on each mismatching accepted pair, holding at 1023, and latch first_err_idx only on the first mismatch of the frame.
REQ-020 SHALL reset the idle counter on every accepted pair and increment it otherwise in RUN; reaching TIMEOUT sets timeout and enters DONE.
REQ-021 SHALL give pair-count completion priority over timeout when both occur on the same edge (timeout stays 0).
REQ-022 SHALL update sum/err_cnt with one-cycle latency after the accepting edge; the final pair is reflected when done is high.
REQ-023 SHALL assert done for exactly one cycle, in DONE, and hold the result outputs stable from DONE until the next start.
REQ-024 SHALL ignore start while in RUN or DONE.
REQ-025 SHALL ignore in_valid beyond the N_PAIRS-th pair in the same cycle stream (no accumulation after the count is reached).

Reset
REQ-026 SHALL, while rst_n=0, force state IDLE and busy=0, done=0, sum=0, err_cnt=0, first_err_idx=0, timeout=0, and all counters to 0, regardless of clk.
REQ-027 SHALL, on reset asserted mid-frame, abandon the frame without a done pulse and require a fresh start after release.

Structure
REQ-028 SHALL place the state encoding (IDLE=0, RUN=1, DONE=2, 2 bits) and default N_PAIRS/TIMEOUT constants in a shared package used by the codebase's buffer stages.
REQ-029 SHALL be a single module with no sub-modules; the expected-value compare is inline logic.

Verification
REQ-030 SHALL cover: start, then 512 consecutive valid pairs (2k+1, 2k+2) -> done once, sum=524800, err_cnt=0, timeout=0.
REQ-031 SHALL cover: clean frame with pair 100 high lane corrupted to 0 -> err_cnt=1, first_err_idx=100, sum=524800-202.
REQ-032 SHALL cover: 300 valid pairs, then in_valid held low -> done after 64 idle cycles, timeout=1, sum equals sum of first 300 pairs.
REQ-033 SHALL cover: in_valid toggled every other cycle and start re-pulsed mid-frame -> same result as REQ-030, re-pulse ignored.
REQ-034 SHALL cover: rst_n pulled low at pair 200 -> all outputs 0, no done; a new start then runs a clean frame to REQ-030 results.

Source files
------------

// File: rtl/pair_stream_checker_pkg.sv
// Shared constants, state encoding and pair record for the buffer-stage checkers.
package pair_stream_checker_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int N_PAIRS_DEF = 512;
  localparam int TIMEOUT_DEF = 64;

  localparam int NUM_LANES = 2;
  localparam int LANE_W    = 16;
  localparam int SUM_W     = 32;
  localparam int ERR_W     = 10;
  localparam int IDX_W     = 9;

  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  // One accepted pair as it travels to the accumulate stage.
  typedef struct packed {
    logic [NUM_LANES-1:0][LANE_W-1:0] lane;
    logic [IDX_W-1:0]                 idx;
    logic                             mis;
  } pair_t;

  // Expected value for lane l of pair k: 2k+1+l, wrapping at 16 bits.
  function automatic logic [LANE_W-1:0] exp_word(input logic [LANE_W-1:0] k, input int l);
    return (k << 1) + LANE_W'(l + 1);
  endfunction

endpackage

// File: rtl/pair_stream_checker.sv
// Checks a frame of N_PAIRS read words (two 16-bit halves) against the
// 2k+1 / 2k+2 ramp, accumulating a lane sum and mismatch statistics.
module pair_stream_checker
  import pair_stream_checker_pkg::*;
#(
  parameter int N_PAIRS = N_PAIRS_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [LANE_W-1:0] data_in1,
  input  logic [LANE_W-1:0] data_in2,
  output logic              busy,
  output logic              done,
  output logic [SUM_W-1:0]  sum,
  output logic [ERR_W-1:0]  err_cnt,
  output logic [IDX_W-1:0]  first_err_idx,
  output logic              timeout
);

  localparam int CNT_W  = $clog2(N_PAIRS + 1);
  localparam int IDLE_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  N_LAST = CNT_W'(N_PAIRS);
  localparam logic [IDLE_W-1:0] T_LAST = IDLE_W'(TIMEOUT);

  state_t                          state, state_nxt;
  logic [CNT_W-1:0]                pair_cnt;
  logic [IDLE_W-1:0]               idle_cnt;
  logic                            arm, accept, cnt_hit, idle_hit;
  logic [NUM_LANES-1:0][LANE_W-1:0] lane, lane_exp;
  logic [NUM_LANES-1:0]            lane_ok;
  logic [LANE_W-1:0]               k16;
  logic                            vld_q;
  pair_t                           pipe_q;

  assign lane     = {data_in2, data_in1};
  assign k16      = LANE_W'(pair_cnt);
  assign cnt_hit  = (pair_cnt == N_LAST);
  assign idle_hit = (idle_cnt == T_LAST);
  assign arm      = (state == IDLE) && start;
  // Once the count is reached the frame is closed even though RUN lasts one more cycle.
  assign accept   = (state == RUN) && in_valid && !cnt_hit;

  assign busy = (state == RUN);
  assign done = (state == DONE);

  // Per-lane expected-value compare against the ramp.
  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    assign lane_exp[l] = exp_word(k16, l);
    assign lane_ok[l]  = (lane[l] == lane_exp[l]);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state: count completion is tested first so it wins over an idle timeout.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (cnt_hit || idle_hit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Pair and idle counters; both cleared when a frame is armed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pair_cnt <= '0;
      idle_cnt <= '0;
    end else if (arm) begin
      pair_cnt <= '0;
      idle_cnt <= '0;
    end else if (state == RUN) begin
      if (accept) begin
        pair_cnt <= pair_cnt + CNT_W'(1);
        idle_cnt <= '0;
      end else if (!idle_hit) begin
        idle_cnt <= idle_cnt + IDLE_W'(1);
      end
    end
  end

  // Capture stage: registers the accepted pair and its compare result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= 1'b0;
      pipe_q <= '0;
    end else begin
      vld_q <= accept;
      if (accept) begin
        pipe_q.lane <= lane;
        pipe_q.idx  <= IDX_W'(pair_cnt);
        pipe_q.mis  <= !(&lane_ok);
      end
    end
  end

  // Accumulate stage: result outputs, one cycle behind acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum           <= '0;
      err_cnt       <= '0;
      first_err_idx <= '0;
      timeout       <= 1'b0;
    end else if (arm) begin
      sum           <= '0;
      err_cnt       <= '0;
      first_err_idx <= '0;
      timeout       <= 1'b0;
    end else begin
      if (vld_q) begin
        sum <= sum + SUM_W'(pipe_q.lane[0]) + SUM_W'(pipe_q.lane[1]);
        if (pipe_q.mis) begin
          if (err_cnt != ERR_MAX) err_cnt <= err_cnt + ERR_W'(1);
          if (err_cnt == '0)      first_err_idx <= pipe_q.idx;
        end
      end
      if ((state == RUN) && idle_hit && !cnt_hit) timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pair_stream_checker.sv
// Directed bench for pair_stream_checker: clean, corrupted, timeout,
// throttled/restart and mid-frame reset frames.
module tb_pair_stream_checker;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] data_in1 = '0;
  logic [15:0] data_in2 = '0;
  logic        busy, done, timeout;
  logic [31:0] sum;
  logic [9:0]  err_cnt;
  logic [8:0]  first_err_idx;

  int pass_cnt = 0;
  int total_cnt = 0;
  int done_total = 0;

  pair_stream_checker dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .data_in1(data_in1), .data_in2(data_in2), .busy(busy), .done(done),
    .sum(sum), .err_cnt(err_cnt), .first_err_idx(first_err_idx), .timeout(timeout)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_total++;

  // Sum of lanes over pairs 0..n-1: sum(4k+3) = 2n^2 + n.
  function automatic logic [31:0] ramp_sum(input int n);
    return 32'(2 * n * n + n);
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  // Drive n ramp pairs; bad_idx gets a zero high lane, toggle inserts an idle
  // cycle before each pair, restart_at re-pulses start during that idle cycle.
  task automatic send_pairs(input int n, input int bad_idx, input bit toggle, input int restart_at);
    for (int k = 0; k < n; k++) begin
      if (toggle) begin
        in_valid = 1'b0;
        if (k == restart_at) start = 1'b1;
        tick();
        start = 1'b0;
      end
      in_valid = 1'b1;
      data_in1 = 16'(2 * k + 1);
      data_in2 = (k == bad_idx) ? 16'd0 : 16'(2 * k + 2);
      tick();
    end
    in_valid = 1'b0;
    data_in1 = '0;
    data_in2 = '0;
  endtask

  // Returns the negedge index at which done was first seen, 0 if never.
  task automatic wait_done(input int bound, output int n);
    int base;
    base = done_total;
    n = 0;
    for (int i = 1; i <= bound; i++) begin
      @(negedge clk); #1;
      if (done_total != base) begin n = i; break; end
    end
  endtask

  task automatic test_reset();
    #3;
    total_cnt++; if ({busy, done, timeout} !== 3'b000) $display("FAIL rst_flags got %b want 000", {busy, done, timeout}); else pass_cnt++;
    total_cnt++; if (sum !== 32'd0) $display("FAIL rst_sum got %0d want 0", sum); else pass_cnt++;
    total_cnt++; if (err_cnt !== 10'd0) $display("FAIL rst_err got %0d want 0", err_cnt); else pass_cnt++;
    total_cnt++; if (first_err_idx !== 9'd0) $display("FAIL rst_idx got %0d want 0", first_err_idx); else pass_cnt++;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b1; data_in1 = 16'h1234; data_in2 = 16'h5678;
    repeat (3) tick();
    in_valid = 1'b0;
    total_cnt++; if (sum !== 32'd0 || busy !== 1'b0) $display("FAIL idle_ignore sum %0d busy %b want 0 0", sum, busy); else pass_cnt++;
  endtask

  task automatic test_clean_frame();
    int n, base;
    pulse_start();
    total_cnt++; if (busy !== 1'b1) $display("FAIL clean_busy got %b want 1", busy); else pass_cnt++;
    base = done_total;
    send_pairs(512, -1, 1'b0, -1);
    wait_done(10, n);
    total_cnt++; if (n !== 2) $display("FAIL clean_done_lat got %0d want 2", n); else pass_cnt++;
    total_cnt++; if (sum !== 32'd524800) $display("FAIL clean_sum got %0d want 524800", sum); else pass_cnt++;
    total_cnt++; if (err_cnt !== 10'd0) $display("FAIL clean_err got %0d want 0", err_cnt); else pass_cnt++;
    total_cnt++; if (timeout !== 1'b0) $display("FAIL clean_timeout got %b want 0", timeout); else pass_cnt++;
    in_valid = 1'b1; data_in1 = 16'd7; data_in2 = 16'd9;
    repeat (4) tick();
    in_valid = 1'b0;
    total_cnt++; if (done_total - base !== 1) $display("FAIL clean_done_once got %0d want 1", done_total - base); else pass_cnt++;
    total_cnt++; if (sum !== 32'd524800 || busy !== 1'b0) $display("FAIL clean_hold sum %0d busy %b want 524800 0", sum, busy); else pass_cnt++;
  endtask

  task automatic test_corrupt();
    int n;
    pulse_start();
    total_cnt++; if (sum !== 32'd0 || err_cnt !== 10'd0) $display("FAIL arm_clear sum %0d err %0d want 0 0", sum, err_cnt); else pass_cnt++;
    send_pairs(512, 100, 1'b0, -1);
    wait_done(10, n);
    total_cnt++; if (n === 0) $display("FAIL corrupt_done got none want pulse"); else pass_cnt++;
    total_cnt++; if (err_cnt !== 10'd1) $display("FAIL corrupt_err got %0d want 1", err_cnt); else pass_cnt++;
    total_cnt++; if (first_err_idx !== 9'd100) $display("FAIL corrupt_idx got %0d want 100", first_err_idx); else pass_cnt++;
    total_cnt++; if (sum !== 32'd524598) $display("FAIL corrupt_sum got %0d want 524598", sum); else pass_cnt++;
    tick();
  endtask

  task automatic test_timeout();
    int n;
    pulse_start();
    send_pairs(300, -1, 1'b0, -1);
    wait_done(100, n);
    total_cnt++; if (n !== 66) $display("FAIL to_done_lat got %0d want 66", n); else pass_cnt++;
    total_cnt++; if (timeout !== 1'b1) $display("FAIL to_flag got %b want 1", timeout); else pass_cnt++;
    total_cnt++; if (sum !== ramp_sum(300)) $display("FAIL to_sum got %0d want %0d", sum, ramp_sum(300)); else pass_cnt++;
    total_cnt++; if (err_cnt !== 10'd0) $display("FAIL to_err got %0d want 0", err_cnt); else pass_cnt++;
    repeat (3) tick();
    total_cnt++; if (timeout !== 1'b1) $display("FAIL to_sticky got %b want 1", timeout); else pass_cnt++;
  endtask

  task automatic test_toggle_restart();
    int n, base;
    pulse_start();
    total_cnt++; if (timeout !== 1'b0) $display("FAIL tog_arm_to got %b want 0", timeout); else pass_cnt++;
    base = done_total;
    send_pairs(512, -1, 1'b1, 250);
    wait_done(10, n);
    total_cnt++; if (n !== 2) $display("FAIL tog_done_lat got %0d want 2", n); else pass_cnt++;
    total_cnt++; if (sum !== 32'd524800) $display("FAIL tog_sum got %0d want 524800", sum); else pass_cnt++;
    total_cnt++; if (err_cnt !== 10'd0 || timeout !== 1'b0) $display("FAIL tog_err err %0d to %b want 0 0", err_cnt, timeout); else pass_cnt++;
    repeat (2) tick();
    total_cnt++; if (done_total - base !== 1) $display("FAIL tog_done_once got %0d want 1", done_total - base); else pass_cnt++;
  endtask

  task automatic test_reset_mid_frame();
    int base;
    pulse_start();
    base = done_total;
    send_pairs(200, -1, 1'b0, -1);
    #2;
    rst_n = 1'b0;
    #2;
    total_cnt++; if ({busy, done, timeout} !== 3'b000) $display("FAIL mid_flags got %b want 000", {busy, done, timeout}); else pass_cnt++;
    total_cnt++; if (sum !== 32'd0 || err_cnt !== 10'd0 || first_err_idx !== 9'd0) $display("FAIL mid_outs sum %0d err %0d idx %0d want 0", sum, err_cnt, first_err_idx); else pass_cnt++;
    repeat (2) tick();
    rst_n = 1'b1;
    in_valid = 1'b1; data_in1 = 16'd1; data_in2 = 16'd2;
    repeat (8) tick();
    in_valid = 1'b0;
    total_cnt++; if (done_total - base !== 0) $display("FAIL mid_no_done got %0d want 0", done_total - base); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0 || sum !== 32'd0) $display("FAIL mid_need_start busy %b sum %0d want 0 0", busy, sum); else pass_cnt++;
    test_clean_frame();
  endtask

  initial begin
    test_reset();
    test_clean_frame();
    test_corrupt();
    test_timeout();
    test_toggle_restart();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got running want finished");
    $fatal(1);
  end

endmodule
